// File: rtl/dds_pkg.sv
// Shared DDS definitions: waveform encodings, default tuning constants and
// the amplitude scaling helper used by the core and the display logic.
package dds_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    localparam logic [23:0] DDS_FTW_INIT = 24'h010000;
    localparam logic [23:0] DDS_FTW_STEP = 24'h001000;
    localparam logic [23:0] DDS_FTW_MIN  = 24'h001000;
    localparam logic [23:0] DDS_FTW_MAX  = 24'h400000;

    function automatic int mid_of(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    // Scale a raw sample around mid-scale by amp/2^amp_w, then clamp to the PWM range.
    function automatic int scale_clamp(input int raw, input int amp,
                                       input int data_w, input int amp_w);
        int diff;
        int res;
        diff = raw - mid_of(data_w);
        res  = mid_of(data_w) + ((diff * amp) >>> amp_w);
        if (res < 0)
            res = 0;
        else if (res > (1 << data_w) - 1)
            res = (1 << data_w) - 1;
        return res;
    endfunction

endpackage

// File: rtl/dds_pwm_multich_if.sv
// Control and monitor bundle between the button/display logic and the DDS core.
// The up/down and sync lines are single-cycle strobes with no ready: every cycle
// a strobe is high counts as one step, and the core always accepts it.
interface dds_pwm_multich_if #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1,
    parameter int ACC_W  = 24,
    parameter int AMP_W  = 4
);
    logic [CH_W-1:0]     ch_sel;
    logic [2*NUM_CH-1:0] wave_sel;
    logic                freq_up;
    logic                freq_dn;
    logic                amp_up;
    logic                amp_dn;
    logic                phase_sync;
    logic [ACC_W-1:0]    ftw_mon;
    logic [AMP_W:0]      amp_mon;

    modport master (
        output ch_sel, wave_sel, freq_up, freq_dn, amp_up, amp_dn, phase_sync,
        input  ftw_mon, amp_mon
    );

    modport slave (
        input  ch_sel, wave_sel, freq_up, freq_dn, amp_up, amp_dn, phase_sync,
        output ftw_mon, amp_mon
    );
endinterface

// File: rtl/dds_sine_lut.sv
// Registered quarter-wave sine ROM, first quadrant only (0..pi/2, half-step offset).
// Quadrant mirroring is left to the caller.
module dds_sine_lut #(
    parameter int DATA_W     = 8,
    parameter int LUT_ADDR_W = 6
) (
    input  logic                  clock,
    input  logic [LUT_ADDR_W-1:0] addr,
    output logic [DATA_W-2:0]     data
);
    logic [5:0] idx6;

    // Base table is 64 x 7 bits; address and data are rescaled to the configured sizes.
    function automatic logic [6:0] base_tbl(input logic [5:0] i);
        case (i)
            6'd0:  return 7'd2;    6'd1:  return 7'd5;    6'd2:  return 7'd8;    6'd3:  return 7'd11;
            6'd4:  return 7'd14;   6'd5:  return 7'd17;   6'd6:  return 7'd20;   6'd7:  return 7'd23;
            6'd8:  return 7'd26;   6'd9:  return 7'd29;   6'd10: return 7'd32;   6'd11: return 7'd35;
            6'd12: return 7'd38;   6'd13: return 7'd41;   6'd14: return 7'd44;   6'd15: return 7'd47;
            6'd16: return 7'd50;   6'd17: return 7'd53;   6'd18: return 7'd56;   6'd19: return 7'd58;
            6'd20: return 7'd61;   6'd21: return 7'd64;   6'd22: return 7'd67;   6'd23: return 7'd69;
            6'd24: return 7'd72;   6'd25: return 7'd74;   6'd26: return 7'd77;   6'd27: return 7'd79;
            6'd28: return 7'd82;   6'd29: return 7'd84;   6'd30: return 7'd86;   6'd31: return 7'd89;
            6'd32: return 7'd91;   6'd33: return 7'd93;   6'd34: return 7'd95;   6'd35: return 7'd97;
            6'd36: return 7'd99;   6'd37: return 7'd101;  6'd38: return 7'd103;  6'd39: return 7'd105;
            6'd40: return 7'd106;  6'd41: return 7'd108;  6'd42: return 7'd110;  6'd43: return 7'd111;
            6'd44: return 7'd113;  6'd45: return 7'd114;  6'd46: return 7'd115;  6'd47: return 7'd117;
            6'd48: return 7'd118;  6'd49: return 7'd119;  6'd50: return 7'd120;  6'd51: return 7'd121;
            6'd52: return 7'd122;  6'd53: return 7'd123;  6'd54: return 7'd124;  6'd55: return 7'd124;
            6'd56: return 7'd125;  6'd57: return 7'd125;  6'd58: return 7'd126;  6'd59: return 7'd126;
            6'd60: return 7'd127;  6'd61: return 7'd127;  6'd62: return 7'd127;  default: return 7'd127;
        endcase
    endfunction

    assign idx6 = 6'((int'(addr) << 6) >> LUT_ADDR_W);

    always_ff @(posedge clock) begin
        data <= (DATA_W-1)'((int'(base_tbl(idx6)) << (DATA_W - 1)) >> 7);
    end
endmodule

// File: rtl/dds_pwm_multich.sv
// Multi-channel DDS: per-channel phase accumulators feed a waveform/scale pipeline
// whose result becomes the PWM duty one frame later.
module dds_pwm_multich
    import dds_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1,
    parameter int ACC_W      = 24,
    parameter int DATA_W     = 8,
    parameter int LUT_ADDR_W = 6,
    parameter int AMP_W      = 4,
    parameter logic [ACC_W-1:0] FTW_INIT = DDS_FTW_INIT,
    parameter logic [ACC_W-1:0] FTW_STEP = DDS_FTW_STEP,
    parameter logic [ACC_W-1:0] FTW_MIN  = DDS_FTW_MIN,
    parameter logic [ACC_W-1:0] FTW_MAX  = DDS_FTW_MAX
) (
    input  logic                 clock,
    input  logic                 reset,
    dds_pwm_multich_if.slave     ctrl,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic                 frame_tick
);
    localparam logic [AMP_W:0]    AMP_FULL = (AMP_W+1)'(1 << AMP_W);
    localparam logic [AMP_W:0]    AMP_ONE  = (AMP_W+1)'(1);
    localparam logic [DATA_W-1:0] MID_V    = DATA_W'(mid_of(DATA_W));

    logic [DATA_W-1:0]     pwm_cnt;
    logic [ACC_W-1:0]      acc       [NUM_CH];
    logic [ACC_W-1:0]      ftw       [NUM_CH];
    logic [AMP_W:0]        amp       [NUM_CH];
    logic [DATA_W-1:0]     duty      [NUM_CH];
    logic [DATA_W-1:0]     duty_next [NUM_CH];
    logic [DATA_W-1:0]     raw       [NUM_CH];
    logic [DATA_W-1:0]     raw_c     [NUM_CH];
    logic [DATA_W-1:0]     phase     [NUM_CH];
    logic [LUT_ADDR_W-1:0] lut_addr  [NUM_CH];
    logic [DATA_W-2:0]     rom_q     [NUM_CH];
    wave_e                 wave_r    [NUM_CH];
    logic                  sync_pend;
    logic [2:0]            stage;
    logic [CH_W-1:0]       sel;
    logic                  ch_ok;

    assign frame_tick = &pwm_cnt;
    assign sel        = ctrl.ch_sel;
    assign ch_ok      = (int'(sel) < NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign phase[g]    = acc[g][ACC_W-1 -: DATA_W];
        // Second and fourth quadrants read the table backwards.
        assign lut_addr[g] = phase[g][DATA_W-2] ? ~phase[g][DATA_W-3 -: LUT_ADDR_W]
                                                :  phase[g][DATA_W-3 -: LUT_ADDR_W];
        dds_sine_lut #(.DATA_W(DATA_W), .LUT_ADDR_W(LUT_ADDR_W)) u_lut (
            .clock (clock),
            .addr  (lut_addr[g]),
            .data  (rom_q[g])
        );
    end

    // Frame counter, accumulators and duty hand-over at the frame boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt   <= '0;
            sync_pend <= 1'b0;
            stage     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c]    <= '0;
                duty[c]   <= '0;
                wave_r[c] <= WAVE_SINE;
            end
        end else begin
            pwm_cnt <= pwm_cnt + DATA_W'(1);
            stage   <= {stage[1:0], frame_tick};
            if (frame_tick) begin
                sync_pend <= 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    acc[c]    <= (sync_pend || ctrl.phase_sync) ? '0 : acc[c] + ftw[c];
                    duty[c]   <= duty_next[c];
                    wave_r[c] <= wave_e'(ctrl.wave_sel[2*c +: 2]);
                end
            end else if (ctrl.phase_sync) begin
                sync_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            raw_c[c] = phase[c];
            case (wave_r[c])
                WAVE_SINE:   raw_c[c] = phase[c][DATA_W-1]
                                        ? (MID_V - DATA_W'(1) - {1'b0, rom_q[c]})
                                        : (MID_V + {1'b0, rom_q[c]});
                WAVE_SQUARE: raw_c[c] = phase[c][DATA_W-1] ? '1 : '0;
                WAVE_TRI:    raw_c[c] = phase[c][DATA_W-1] ? ~{phase[c][DATA_W-2:0], 1'b0}
                                                           :  {phase[c][DATA_W-2:0], 1'b0};
                default:     raw_c[c] = phase[c];
            endcase
        end
    end

    // stage[1]: ROM output for the new phase is valid; stage[2]: raw sample is valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                raw[c]       <= '0;
                duty_next[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (stage[1])
                    raw[c] <= raw_c[c];
                if (stage[2])
                    duty_next[c] <= DATA_W'(scale_clamp(int'(raw[c]), int'(amp[c]), DATA_W, AMP_W));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                pwm_out[c] <= (pwm_cnt < duty[c]);
        end
    end

    // Button steps apply to the selected channel only; opposing strobes cancel.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ftw[c] <= FTW_INIT;
                amp[c] <= AMP_FULL;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_ok && int'(sel) == c) begin
                    if (ctrl.freq_up && !ctrl.freq_dn)
                        ftw[c] <= (ftw[c] >= FTW_MAX - FTW_STEP) ? FTW_MAX : ftw[c] + FTW_STEP;
                    else if (ctrl.freq_dn && !ctrl.freq_up)
                        ftw[c] <= (ftw[c] <= FTW_MIN + FTW_STEP) ? FTW_MIN : ftw[c] - FTW_STEP;
                    if (ctrl.amp_up && !ctrl.amp_dn && amp[c] != AMP_FULL)
                        amp[c] <= amp[c] + AMP_ONE;
                    else if (ctrl.amp_dn && !ctrl.amp_up && amp[c] != '0)
                        amp[c] <= amp[c] - AMP_ONE;
                end
            end
        end
    end

    always_comb begin
        ctrl.ftw_mon = '0;
        ctrl.amp_mon = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_ok && int'(sel) == c) begin
                ctrl.ftw_mon = ftw[c];
                ctrl.amp_mon = amp[c];
            end
        end
    end
endmodule

// File: tb/tb_dds_pwm_multich.sv
// Directed bench for dds_pwm_multich: frame timing, waveform duty, controls,
// phase sync and mid-frame reset, with hand-computed expected values.
module tb_dds_pwm_multich;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] pwm_out;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  dds_pwm_multich_if #(.NUM_CH(2), .CH_W(1), .ACC_W(24), .AMP_W(4)) ctrl_if ();

  dds_pwm_multich dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl       (ctrl_if.slave),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  // clock / reset
  always #5 clock = ~clock;

  // driver tasks (all called at a negedge; return at a negedge)
  task automatic idle_inputs();
    ctrl_if.freq_up = 1'b0;
    ctrl_if.freq_dn = 1'b0;
    ctrl_if.amp_up = 1'b0;
    ctrl_if.amp_dn = 1'b0;
    ctrl_if.phase_sync = 1'b0;
  endtask

  task automatic pulse(input int ch, input bit fu, input bit fd, input bit au, input bit ad, input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_if.ch_sel = 1'(ch);
      ctrl_if.freq_up = fu;
      ctrl_if.freq_dn = fd;
      ctrl_if.amp_up = au;
      ctrl_if.amp_dn = ad;
      @(negedge clock);
    end
    idle_inputs();
  endtask

  // Window: 256 samples starting at the negedge where pwm_cnt==1.
  task automatic measure_frame(output int h0, output int h1, output int tick_pos, output int tick_n);
    h0 = 0; h1 = 0; tick_pos = -1; tick_n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      if (frame_tick) begin
        tick_n++;
        tick_pos = i;
      end
    end
  endtask

  task automatic sync_to_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (frame_tick) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL frame_tick_timeout: got no tick in 300 cycles, required one");
      errors++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle_inputs();
    ctrl_if.ch_sel = 1'b0;
    ctrl_if.wave_sel = 4'b0111;  // ch1 square, ch0 saw
    reset = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (pwm_out !== 2'b00) begin $display("FAIL reset_pwm: got %b required 00", pwm_out); errors++; end
    checks++;
    if (frame_tick !== 1'b0) begin $display("FAIL reset_tick: got %b required 0", frame_tick); errors++; end
    for (int c = 0; c < 2; c++) begin
      ctrl_if.ch_sel = 1'(c);
      #1;
      checks++;
      if (ctrl_if.ftw_mon !== 24'h010000) begin
        $display("FAIL reset_ftw ch%0d: got %h required 010000", c, ctrl_if.ftw_mon); errors++;
      end
      checks++;
      if (ctrl_if.amp_mon !== 5'd16) begin
        $display("FAIL reset_amp ch%0d: got %0d required 16", c, ctrl_if.amp_mon); errors++;
      end
    end
    ctrl_if.ch_sel = 1'b0;
    reset = 1'b0;
  endtask

  // ch0 saw amp 16; ch1 square amp 8. Duty(frame f) = sample of phase f-1 (0 for f<1, ch1 also f=1).
  task automatic test_saw_square();
    int h0, h1, tp, tn;
    logic [8:0] exp0;
    int exp1;
    for (int f = 0; f < 258; f++) exp_q.push_back(9'((f == 0) ? 0 : ((f - 1) % 256)));
    for (int f = 0; f < 258; f++) begin
      if (f == 0) begin
        fork
          begin
            @(negedge clock);
            pulse(1, 0, 0, 0, 1, 8);
          end
          measure_frame(h0, h1, tp, tn);
        join
        ctrl_if.ch_sel = 1'b1;
        #1;
        checks++;
        if (ctrl_if.amp_mon !== 5'd8) begin $display("FAIL amp_dn8: got %0d required 8", ctrl_if.amp_mon); errors++; end
      end else begin
        measure_frame(h0, h1, tp, tn);
      end
      exp0 = exp_q.pop_front();
      exp1 = (f < 2) ? 0 : ((((f - 1) % 256) < 128) ? 64 : 191);
      checks++;
      if (h0 !== int'(exp0)) begin $display("FAIL saw_ch0 frame %0d: got %0d required %0d", f, h0, exp0); errors++; end
      checks++;
      if (h1 !== exp1) begin $display("FAIL square_ch1 frame %0d: got %0d required %0d", f, h1, exp1); errors++; end
      checks++;
      if (tp !== 254 || tn !== 1) begin
        $display("FAIL tick_pos frame %0d: got pos %0d count %0d required pos 254 count 1", f, tp, tn); errors++;
      end
    end
  endtask

  task automatic test_amp_limits();
    int h0, h1, tp, tn;
    pulse(1, 0, 0, 0, 1, 20);
    ctrl_if.ch_sel = 1'b1;
    #1;
    checks++;
    if (ctrl_if.amp_mon !== 5'd0) begin $display("FAIL amp_floor: got %0d required 0", ctrl_if.amp_mon); errors++; end
    pulse(0, 0, 0, 1, 0, 3);
    pulse(0, 0, 0, 1, 1, 1);
    ctrl_if.ch_sel = 1'b0;
    #1;
    checks++;
    if (ctrl_if.amp_mon !== 5'd16) begin $display("FAIL amp_ceiling: got %0d required 16", ctrl_if.amp_mon); errors++; end
    sync_to_frame();
    measure_frame(h0, h1, tp, tn);
    measure_frame(h0, h1, tp, tn);
    checks++;
    if (h1 !== 128) begin $display("FAIL amp_zero_duty: got %0d required 128", h1); errors++; end
  endtask

  task automatic test_freq();
    pulse(1, 1, 0, 0, 0, 3);
    ctrl_if.ch_sel = 1'b1;
    #1;
    checks++;
    if (ctrl_if.ftw_mon !== 24'h013000) begin $display("FAIL freq_up3 ch1: got %h required 013000", ctrl_if.ftw_mon); errors++; end
    ctrl_if.ch_sel = 1'b0;
    #1;
    checks++;
    if (ctrl_if.ftw_mon !== 24'h010000) begin $display("FAIL freq_ch0_untouched: got %h required 010000", ctrl_if.ftw_mon); errors++; end
    pulse(1, 1, 1, 0, 0, 1);
    ctrl_if.ch_sel = 1'b1;
    #1;
    checks++;
    if (ctrl_if.ftw_mon !== 24'h013000) begin $display("FAIL freq_both: got %h required 013000", ctrl_if.ftw_mon); errors++; end
    pulse(1, 0, 1, 0, 0, 300);
    ctrl_if.ch_sel = 1'b1;
    #1;
    checks++;
    if (ctrl_if.ftw_mon !== 24'h001000) begin $display("FAIL freq_floor: got %h required 001000", ctrl_if.ftw_mon); errors++; end
  endtask

  task automatic test_phase_sync();
    int h0, h1, tp, tn;
    int exp_sine[6] = '{130, 133, 136, 139, 142, 145};
    pulse(1, 1, 0, 0, 0, 18);
    pulse(1, 0, 0, 1, 0, 16);
    ctrl_if.ch_sel = 1'b1;
    #1;
    checks++;
    if (ctrl_if.ftw_mon !== 24'h013000) begin $display("FAIL sync_setup_ftw: got %h required 013000", ctrl_if.ftw_mon); errors++; end
    checks++;
    if (ctrl_if.amp_mon !== 5'd16) begin $display("FAIL sync_setup_amp: got %0d required 16", ctrl_if.amp_mon); errors++; end
    ctrl_if.wave_sel = 4'b0000;
    repeat (50) sync_to_frame();
    repeat (100) @(negedge clock);
    ctrl_if.phase_sync = 1'b1;
    @(negedge clock);
    ctrl_if.phase_sync = 1'b0;
    pulse(1, 0, 1, 0, 0, 3);
    sync_to_frame();
    measure_frame(h0, h1, tp, tn);
    for (int k = 0; k < 6; k++) begin
      measure_frame(h0, h1, tp, tn);
      checks++;
      if (h0 !== exp_sine[k]) begin $display("FAIL sync_ch0 frame %0d: got %0d required %0d", k, h0, exp_sine[k]); errors++; end
      checks++;
      if (h1 !== exp_sine[k]) begin $display("FAIL sync_ch1 frame %0d: got %0d required %0d", k, h1, exp_sine[k]); errors++; end
    end
  endtask

  task automatic test_reset_mid_frame();
    int h0, h1, tp, tn;
    pulse(1, 1, 0, 0, 0, 2);
    pulse(0, 0, 0, 0, 1, 5);
    sync_to_frame();
    repeat (100) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (pwm_out !== 2'b00 || frame_tick !== 1'b0) begin
      $display("FAIL midreset_out: got pwm %b tick %b required 00 0", pwm_out, frame_tick); errors++;
    end
    for (int c = 0; c < 2; c++) begin
      ctrl_if.ch_sel = 1'(c);
      #1;
      checks++;
      if (ctrl_if.ftw_mon !== 24'h010000 || ctrl_if.amp_mon !== 5'd16) begin
        $display("FAIL midreset_regs ch%0d: got ftw %h amp %0d required 010000 16", c, ctrl_if.ftw_mon, ctrl_if.amp_mon); errors++;
      end
    end
    @(negedge clock);
    reset = 1'b0;
    for (int f = 0; f < 2; f++) begin
      measure_frame(h0, h1, tp, tn);
      checks++;
      if (h0 !== 0 || h1 !== 0) begin $display("FAIL midreset_pwm frame %0d: got %0d/%0d required 0/0", f, h0, h1); errors++; end
      checks++;
      if (tp !== 254 || tn !== 1) begin
        $display("FAIL midreset_tick frame %0d: got pos %0d count %0d required pos 254 count 1", f, tp, tn); errors++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ctrl_if.ch_sel = 1'b0;
    ctrl_if.wave_sel = '0;
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_saw_square();
    test_amp_limits();
    test_freq();
    test_phase_sync();
    test_reset_mid_frame();
    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dds_pwm_multich.md
Name: dds_pwm_multich

Overview:
Parametrised multi-channel DDS engine. It generates NUM_CH independent waveforms (sine, square, triangle or sawtooth) from phase accumulators and drives each one out as a PWM bit. Per-channel frequency and amplitude are adjusted by single-cycle control pulses from the debounced board buttons. Monitor outputs for the selected channel feed the seven-segment display logic. It replaces the single-channel core inside the DDS top level.

Parameters:
NUM_CH, 2, number of channels (>=2)
CH_W, 1, width of ch_sel, equal to clog2(NUM_CH)
ACC_W, 24, phase accumulator and tuning-word width
DATA_W, 8, sample/PWM resolution; PWM frame is 2^DATA_W clocks (>=4)
LUT_ADDR_W, 6, quarter-wave sine LUT address width (<=DATA_W-2)
AMP_W, 4, amplitude shift; amp range 0..2^AMP_W
FTW_INIT, 24'h010000, reset tuning word for all channels
FTW_STEP, 24'h001000, tuning word increment/decrement per pulse
FTW_MIN, 24'h001000, lower saturation limit
FTW_MAX, 24'h400000, upper saturation limit

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ch_sel  in  CH_W  channel targeted by the control pulses and the monitors
wave_sel  in  2*NUM_CH  per-channel waveform: 0 sine, 1 square, 2 triangle, 3 saw
freq_up  in  1  one-cycle pulse, raise FTW of ch_sel
freq_dn  in  1  one-cycle pulse, lower FTW of ch_sel
amp_up  in  1  one-cycle pulse, raise amp of ch_sel
amp_dn  in  1  one-cycle pulse, lower amp of ch_sel
phase_sync  in  1  one-cycle pulse; zero all accumulators at the next frame boundary
pwm_out  out  NUM_CH  PWM output per channel
frame_tick  out  1  one-cycle pulse on the last clock of each PWM frame
ftw_mon  out  ACC_W  FTW of ch_sel
amp_mon  out  AMP_W+1  amp of ch_sel

Behaviour:
- Reset (synchronous, active-high) sets the following. The block restarts cleanly from any point, including mid-frame.
  - pwm_cnt=0, all acc=0, all duty=0, pwm_out=0, frame_tick=0.
  - All FTW=FTW_INIT; all amp=2^AMP_W; pending sync cleared.
- pwm_cnt is a free-running DATA_W-bit counter. frame_tick=1 when pwm_cnt==2^DATA_W-1; the first tick occurs 2^DATA_W-1 cycles after reset release.
- pwm_out[c] = registered (pwm_cnt < duty[c]).
  - duty=0 gives a constant low output.
  - duty=2^DATA_W-1 gives high on all but one cycle per frame.
- At a frame boundary (frame_tick cycle):
  - acc[c] += FTW[c], wrapping modulo 2^ACC_W.
  - If phase_sync is pending or asserted this cycle, acc[c]=0 for all channels instead, and pending is cleared.
  - wave_sel is sampled per channel.
- Sample pipeline, started by the boundary. p = acc[ACC_W-1 -: DATA_W].
  - Cycle +1: raw waveform registered.
    - saw = p.
    - square = p[MSB] ? all-ones : 0.
    - triangle = p[MSB] ? ~{p[DATA_W-2:0],0} : {p[DATA_W-2:0],0}.
    - sine = quarter-wave LUT lookup with quadrant mirroring, centred on MID=2^(DATA_W-1).
  - Cycle +2: scaled = MID + (((raw-MID) signed * amp) >>> AMP_W), clamped to 0..2^DATA_W-1, held in duty_next.
  - duty[c] <= duty_next[c] at the following boundary. Each frame therefore uses the sample computed from the phase set one frame earlier; latency is exactly one frame.
- Control pulses act on channel ch_sel in the same cycle they are asserted.
  - freq_up: FTW += FTW_STEP, saturating at FTW_MAX.
  - freq_dn: FTW -= FTW_STEP, saturating at FTW_MIN.
  - amp_up / amp_dn: +1 / -1, saturating at 2^AMP_W and 0.
  - freq_up and freq_dn together: no change. amp_up and amp_dn together: no change.
  - ch_sel >= NUM_CH: pulses ignored; monitors read 0.
  - FTW or amp changes take effect at the next boundary.
- ftw_mon and amp_mon are combinational muxes of the channel registers.

Decomposition:
- Shared package dds_pkg holds:
  - wave encodings WAVE_SINE/SQUARE/TRI/SAW;
  - MID and the scaling/clamp function;
  - the default FTW constants, reused by the top level and the display logic.
- One sub-module, dds_sine_lut: a registered quarter-wave ROM with 2^LUT_ADDR_W entries of DATA_W-1 bits. Mirroring is done in dds_pwm_multich.

Test Plan:
- Reset check: hold reset 10 cycles.
  - Required: pwm_out=0, ftw_mon=0x010000, amp_mon=16.
  - Required: frame_tick at cycle 255 after release, then every 256 cycles.
- Ch0 saw at amp 16, FTW 0x010000:
  - Required: duty of frame k+1 equals k (0, 1, 2, ...).
  - Required: pwm_out[0] high count per frame increments by 1 and wraps 255 -> 0.
- Ch1 square with 8 amp_dn pulses:
  - Required: amp_mon=8.
  - Required: duty alternates 191 / 64 every 128 frames.
  - Required: 20 further amp_dn pulses leave amp_mon=0, duty=128.
- Frequency control:
  - 3 freq_up on ch1: ftw_mon=0x013000 with ch_sel=1; ch0 stays 0x010000.
  - freq_up and freq_dn together: unchanged.
  - 300 freq_dn: ftw_mon=0x001000.
- Phase sync: ch0 FTW 0x010000 and ch1 FTW 0x013000, run 50 frames, pulse phase_sync mid-frame, then set equal FTW.
  - Required: both accumulators are 0 at the next boundary.
  - Required: duty[0]==duty[1] in every later frame.
- Reset mid-frame at pwm_cnt=100 after config changes:
  - Required: all reset values restored on the next cycle.
  - Required: pwm_out stays 0 for the first two frames.
